// File: rtl/instr_encoder_if.sv
// Loader bus: decoded field bundle in, encoded word out to IMEM.
// The slave side is the encoder; the master side drives bundles and memory.
interface instr_encoder_if #(
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [2:0]        in_imm_type;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport slave (
    input  in_valid, in_last, in_imm_type,
    input  in_opcode, in_rd, in_rs1, in_rs2,
    input  in_funct3, in_funct7, in_imm,
    output in_ready,
    output mem_we, mem_addr, mem_wdata,
    input  mem_ready
  );

  modport master (
    output in_valid, in_last, in_imm_type,
    output in_opcode, in_rd, in_rs1, in_rs2,
    output in_funct3, in_funct7, in_imm,
    input  in_ready,
    input  mem_we, mem_addr, mem_wdata,
    output mem_ready
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I field-bundle to instruction-word packer streaming into IMEM.
// Define IMM_CHECK_EN to range-check immediates and drop violating beats.
module instr_encoder #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  instr_encoder_if.slave    bus,
  output logic              busy,
  output logic              done,
  output logic              err_type,
  output logic              err_imm,
  output logic [ADDR_W-1:0] word_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [31:0] imm;
  logic [31:0] word;
  logic        type_ok;
  logic        imm_ok;
  logic        accept;
  logic        complete;
  logic        wr_ok;

  assign imm      = bus.in_imm;
  assign complete = bus.mem_we & bus.mem_ready;
  assign accept   = bus.in_valid & bus.in_ready;
  assign wr_ok    = accept & type_ok & imm_ok;

  always_comb begin
    word    = '0;
    type_ok = 1'b1;
    imm_ok  = 1'b1;
    unique case (bus.in_imm_type)
      3'b000: word = {bus.in_funct7, bus.in_rs2,
                      bus.in_rs1, bus.in_funct3,
                      bus.in_rd, bus.in_opcode};
      3'b001: word = {imm[11:0], bus.in_rs1,
                      bus.in_funct3, bus.in_rd,
                      bus.in_opcode};
      3'b010: word = {imm[31:12], bus.in_rd,
                      bus.in_opcode};
      3'b011: word = {imm[20], imm[10:1], imm[11],
                      imm[19:12], bus.in_rd,
                      bus.in_opcode};
      3'b100: word = {imm[12], imm[10:5], bus.in_rs2,
                      bus.in_rs1, bus.in_funct3,
                      imm[4:1], imm[11],
                      bus.in_opcode};
      3'b101: word = {imm[11:5], bus.in_rs2,
                      bus.in_rs1, bus.in_funct3,
                      imm[4:0], bus.in_opcode};
      default: type_ok = 1'b0;
    endcase
`ifdef IMM_CHECK_EN
    unique case (bus.in_imm_type)
      3'b001, 3'b101:
        imm_ok = (&imm[31:11]) | ~(|imm[31:11]);
      3'b100:
        imm_ok = ((&imm[31:12]) | ~(|imm[31:12]))
                 & ~imm[0];
      3'b011:
        imm_ok = ((&imm[31:20]) | ~(|imm[31:20]))
                 & ~imm[0];
      3'b010:
        imm_ok = ~(|imm[11:0]);
      default: imm_ok = 1'b1;
    endcase
`endif
  end

  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    done         = 1'b0;
    unique case (state)
      IDLE:
        if (start) state_nxt = RUN;
      RUN: begin
        bus.in_ready = ~bus.mem_we | bus.mem_ready;
        if (accept & bus.in_last) state_nxt = DRAIN;
      end
      DRAIN:
        if (~bus.mem_we | bus.mem_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      word_count    <= '0;
      err_type      <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        bus.mem_addr <= base_addr & ~ADDR_W'(3);
        word_count   <= '0;
        err_type     <= 1'b0;
      end else if (complete) begin
        bus.mem_addr <= bus.mem_addr + ADDR_W'(4);
        word_count   <= word_count + ADDR_W'(1);
      end
      // A new word may load in the same cycle the old one retires.
      if (wr_ok) begin
        bus.mem_we    <= 1'b1;
        bus.mem_wdata <= word;
      end else if (complete) begin
        bus.mem_we <= 1'b0;
      end
      if (accept & ~type_ok) err_type <= 1'b1;
    end
  end

`ifdef IMM_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_imm <= 1'b0;
    end else if ((state == IDLE) && start) begin
      err_imm <= 1'b0;
    end else if (accept & type_ok & ~imm_ok) begin
      err_imm <= 1'b1;
    end
  end
`else
  assign err_imm = 1'b0;
`endif

endmodule
